sbus_frame_sequencer: RTL and testbench

//  Receives the raw Futaba S.BUS stream (100 kbaud, 8E2, inverted), validates 25-byte frames
//  (0x0F header, 22 channel bytes, flag byte, 0x00 footer) and hands them byte-by-byte to the

---
 rtl/sbus_frame_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_sbus_frame_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbus_frame_sequencer.sv
// sbus_frame_sequencer
//   Receives a Futaba S.BUS stream (8E2, optionally inverted), validates 25-byte
//   frames (0x0F header, 22 channel bytes, flag byte, 0x00 footer) and presents
//   each accepted frame one byte at a time with a valid/ack handshake.
//   It also reports the failsafe and frame-lost flags, loss of link, and
//   saturating error and overrun counters.
// Ports
//   clk, reset_n   system clock, asynchronous active-low reset
//   sbus_in        raw S.BUS pin (asynchronous)
//   byte_data      current frame byte
//   byte_index     index 0..24 of byte_data
//   byte_valid     byte_data/byte_index valid, held until byte_ack
//   byte_ack       consumer took the byte (ignored while byte_valid=0)
//   frame_done     one-cycle pulse after byte 24 is acked
//   failsafe       bit 3 of the flag byte of the last accepted frame
//   frame_lost     bit 2 of the flag byte of the last accepted frame
//   link_lost      no accepted frame within TIMEOUT_CLKS clocks
//   err_count      saturating count of byte/header/footer/gap errors
//   overrun_count  saturating count of good frames dropped while draining
module sbus_frame_sequencer #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 100_000,
  parameter int INVERT       = 1,
  parameter int GAP_BITS     = 20,
  parameter int TIMEOUT_CLKS = 5_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sbus_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [4:0] byte_index,
  input  logic       byte_ack,
  output logic       frame_done,
  output logic       failsafe,
  output logic       frame_lost,
  output logic       link_lost,
  output logic [7:0] err_count,
  output logic [7:0] overrun_count
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT + 1);
  localparam int GAP_CLKS     = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W        = $clog2(GAP_CLKS + 1);
  localparam int TO_W         = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [BAUD_W-1:0] HALF_BIT_M1 = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_BIT_M1 = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0]  GAP_LIMIT   = GAP_W'(GAP_CLKS);
  localparam logic [TO_W-1:0]   TO_RELOAD   = TO_W'(TIMEOUT_CLKS);
  localparam logic              INV_BIT     = (INVERT != 0);
  localparam logic              PIN_IDLE    = ~INV_BIT;
  localparam logic [4:0]        LAST_IDX    = 5'd24;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP1, RX_STOP2} rx_state_t;
  typedef enum logic [1:0] {F_HUNT, F_ARMED, F_RECV, F_COMMIT} frame_state_t;
  typedef enum logic {D_IDLE, D_SEND} drain_state_t;

  // Even parity over a data byte: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  logic              sync1_r, sync2_r, line_s, tick_s;
  rx_state_t         rx_state_r, rx_next_s;
  logic [BAUD_W-1:0] baud_cnt_r;
  logic [2:0]        bit_cnt_r;
  logic [7:0]        rx_shift_r, rx_byte_r;
  logic              rx_par_r, rx_stop1_r, rx_done_r, rx_err_r;
  logic [GAP_W-1:0]  idle_cnt_r;
  logic              gap_s;
  frame_state_t      frame_state_r, frame_next_s;
  logic              frame_err_s, wr_en_s, commit_s;
  logic [4:0]        wr_idx_r;
  logic [7:0]        wr_buf_r   [1:23];
  logic [7:0]        hold_buf_r [1:23];
  drain_state_t      drain_state_r, drain_next_s;
  logic              accept_s, overrun_s, handshake_s;
  logic [4:0]        next_idx_s;
  logic [7:0]        next_data_s;
  logic [7:0]        byte_data_r, err_count_r, overrun_count_r;
  logic [4:0]        byte_index_r;
  logic              byte_valid_r, frame_done_r, failsafe_r, frame_lost_r, link_lost_r;
  logic [TO_W-1:0]   to_cnt_r;

  assign byte_data     = byte_data_r;
  assign byte_valid    = byte_valid_r;
  assign byte_index    = byte_index_r;
  assign frame_done    = frame_done_r;
  assign failsafe      = failsafe_r;
  assign frame_lost    = frame_lost_r;
  assign link_lost     = link_lost_r;
  assign err_count     = err_count_r;
  assign overrun_count = overrun_count_r;

  // Two-flop synchroniser; resets to the idle pin level so no false start bit appears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= PIN_IDLE;
      sync2_r <= PIN_IDLE;
    end else begin
      sync1_r <= sbus_in;
      sync2_r <= sync1_r;
    end
  end

  // Internally the line is always idle-high.
  assign line_s = sync2_r ^ INV_BIT;
  assign tick_s = (baud_cnt_r == {BAUD_W{1'b0}});
  assign gap_s  = (idle_cnt_r == GAP_LIMIT);

  // State registers of the bit receiver, frame sequencer and drain side.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_r    <= RX_IDLE;
      frame_state_r <= F_HUNT;
      drain_state_r <= D_IDLE;
    end else begin
      rx_state_r    <= rx_next_s;
      frame_state_r <= frame_next_s;
      drain_state_r <= drain_next_s;
    end
  end

  // Bit receiver next state: half-bit start check, then 8 data, parity, two stops.
  always_comb begin
    rx_next_s = rx_state_r;
    case (rx_state_r)
      RX_IDLE:  if (!line_s) rx_next_s = RX_START; else rx_next_s = RX_IDLE;
      RX_START: if (tick_s) rx_next_s = line_s ? RX_IDLE : RX_DATA; else rx_next_s = RX_START;
      RX_DATA:  if (tick_s && bit_cnt_r == 3'd7) rx_next_s = RX_PAR; else rx_next_s = RX_DATA;
      RX_PAR:   if (tick_s) rx_next_s = RX_STOP1; else rx_next_s = RX_PAR;
      RX_STOP1: if (tick_s) rx_next_s = RX_STOP2; else rx_next_s = RX_STOP1;
      RX_STOP2: if (tick_s) rx_next_s = RX_IDLE; else rx_next_s = RX_STOP2;
      default:  rx_next_s = RX_IDLE;
    endcase
  end

  // Bit receiver datapath: bit timer, shift register and the per-byte result strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt_r <= {BAUD_W{1'b0}};
      bit_cnt_r  <= 3'd0;
      rx_shift_r <= 8'h00;
      rx_par_r   <= 1'b0;
      rx_stop1_r <= 1'b0;
      rx_done_r  <= 1'b0;
      rx_err_r   <= 1'b0;
      rx_byte_r  <= 8'h00;
    end else begin
      rx_done_r <= 1'b0;
      if (rx_state_r == RX_IDLE) begin
        baud_cnt_r <= HALF_BIT_M1;
      end else if (tick_s) begin
        baud_cnt_r <= FULL_BIT_M1;
      end else begin
        baud_cnt_r <= baud_cnt_r - {{(BAUD_W-1){1'b0}}, 1'b1};
      end
      if (rx_state_r == RX_START) begin
        bit_cnt_r <= 3'd0;
      end else if (rx_state_r == RX_DATA && tick_s) begin
        bit_cnt_r  <= bit_cnt_r + 3'd1;
        rx_shift_r <= {line_s, rx_shift_r[7:1]};
      end
      if (rx_state_r == RX_PAR && tick_s) rx_par_r <= line_s;
      if (rx_state_r == RX_STOP1 && tick_s) rx_stop1_r <= line_s;
      if (rx_state_r == RX_STOP2 && tick_s) begin
        rx_done_r <= 1'b1;
        rx_byte_r <= rx_shift_r;
        rx_err_r  <= (rx_par_r != even_parity(rx_shift_r)) || !rx_stop1_r || !line_s;
      end
    end
  end

  // Idle-line timer: counts only while the receiver is idle with the line high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_r <= {GAP_W{1'b0}};
    end else if (rx_state_r == RX_IDLE && line_s) begin
      if (!gap_s) idle_cnt_r <= idle_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
    end else begin
      idle_cnt_r <= {GAP_W{1'b0}};
    end
  end

  // Frame sequencer: gap-qualified header, 23 payload bytes, footer, then commit.
  always_comb begin
    frame_next_s = frame_state_r;
    frame_err_s  = 1'b0;
    wr_en_s      = 1'b0;
    commit_s     = 1'b0;
    case (frame_state_r)
      F_HUNT: begin
        if (gap_s) frame_next_s = F_ARMED; else frame_next_s = F_HUNT;
      end
      F_ARMED: begin
        if (rx_done_r) begin
          if (rx_err_r || rx_byte_r != 8'h0F) begin
            frame_err_s  = 1'b1;
            frame_next_s = F_HUNT;
          end else begin
            frame_next_s = F_RECV;
          end
        end else begin
          frame_next_s = F_ARMED;
        end
      end
      F_RECV: begin
        if (rx_done_r) begin
          if (rx_err_r) begin
            frame_err_s  = 1'b1;
            frame_next_s = F_HUNT;
          end else if (wr_idx_r == LAST_IDX) begin
            if (rx_byte_r != 8'h00) begin
              frame_err_s  = 1'b1;
              frame_next_s = F_HUNT;
            end else begin
              frame_next_s = F_COMMIT;
            end
          end else begin
            wr_en_s = 1'b1;
          end
        end else if (gap_s) begin
          // A long idle inside a frame means the transmitter gave up mid-frame.
          frame_err_s  = 1'b1;
          frame_next_s = F_HUNT;
        end else begin
          frame_next_s = F_RECV;
        end
      end
      F_COMMIT: begin
        commit_s     = 1'b1;
        frame_next_s = F_ARMED;
      end
      default: frame_next_s = F_HUNT;
    endcase
  end

  // Write buffer: header and footer are fixed, so only bytes 1..23 are stored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_idx_r <= 5'd0;
      for (int i = 1; i <= 23; i++) wr_buf_r[i] <= 8'h00;
    end else if (frame_state_r == F_ARMED) begin
      wr_idx_r <= 5'd1;
    end else if (wr_en_s) begin
      wr_buf_r[wr_idx_r] <= rx_byte_r;
      wr_idx_r           <= wr_idx_r + 5'd1;
    end
  end

  // Drain side: a commit is accepted only when no frame is still being handed out.
  always_comb begin
    drain_next_s = drain_state_r;
    accept_s     = commit_s && (drain_state_r == D_IDLE);
    overrun_s    = commit_s && (drain_state_r == D_SEND);
    handshake_s  = (drain_state_r == D_SEND) && byte_ack;
    next_idx_s   = byte_index_r + 5'd1;
    if (next_idx_s >= LAST_IDX) next_data_s = 8'h00; else next_data_s = hold_buf_r[next_idx_s];
    case (drain_state_r)
      D_IDLE: if (accept_s) drain_next_s = D_SEND; else drain_next_s = D_IDLE;
      D_SEND: if (handshake_s && byte_index_r == LAST_IDX) drain_next_s = D_IDLE; else drain_next_s = D_SEND;
      default: drain_next_s = D_IDLE;
    endcase
  end

  // Hold buffer, flags and the registered byte handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i <= 23; i++) hold_buf_r[i] <= 8'h00;
      failsafe_r   <= 1'b0;
      frame_lost_r <= 1'b0;
      byte_valid_r <= 1'b0;
      byte_index_r <= 5'd0;
      byte_data_r  <= 8'h00;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (accept_s) begin
        hold_buf_r   <= wr_buf_r;
        failsafe_r   <= wr_buf_r[23][3];
        frame_lost_r <= wr_buf_r[23][2];
        byte_valid_r <= 1'b1;
        byte_index_r <= 5'd0;
        byte_data_r  <= 8'h0F;
      end else if (handshake_s) begin
        if (byte_index_r == LAST_IDX) begin
          byte_valid_r <= 1'b0;
          frame_done_r <= 1'b1;
        end else begin
          byte_index_r <= next_idx_s;
          byte_data_r  <= next_data_s;
        end
      end
    end
  end

  // Saturating error and overrun counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count_r     <= 8'h00;
      overrun_count_r <= 8'h00;
    end else begin
      if (frame_err_s && err_count_r != 8'hFF) err_count_r <= err_count_r + 8'd1;
      if (overrun_s && overrun_count_r != 8'hFF) overrun_count_r <= overrun_count_r + 8'd1;
    end
  end

  // Link watchdog: reloads on every accepted frame, link_lost is sticky once it expires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_r    <= {TO_W{1'b0}};
      link_lost_r <= 1'b1;
    end else if (accept_s) begin
      to_cnt_r    <= TO_RELOAD;
      link_lost_r <= 1'b0;
    end else if (to_cnt_r != {TO_W{1'b0}}) begin
      to_cnt_r <= to_cnt_r - {{(TO_W-1){1'b0}}, 1'b1};
      if (to_cnt_r == {{(TO_W-1){1'b0}}, 1'b1}) link_lost_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sbus_frame_sequencer.sv
// Testbench for sbus_frame_sequencer: drives S.BUS frames on the pin, predicts
// deliveries and counters from frame-level rules, and checks the byte stream
// through a scoreboard queue popped by an independent monitor.
module tb_sbus_frame_sequencer;
  localparam int CLK_HZ   = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_HZ / BAUD;
  localparam int GAP_BITS = 20;
  localparam int TO       = 8000;

  logic clk = 1'b0;
  logic reset_n, sbus_in, byte_ack;
  logic [7:0] byte_data, err_count, overrun_count;
  logic [4:0] byte_index;
  logic byte_valid, frame_done, failsafe, frame_lost, link_lost;

  sbus_frame_sequencer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .INVERT(1),
                         .GAP_BITS(GAP_BITS), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .reset_n(reset_n), .sbus_in(sbus_in),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_index(byte_index),
    .byte_ack(byte_ack), .frame_done(frame_done), .failsafe(failsafe),
    .frame_lost(frame_lost), .link_lost(link_lost),
    .err_count(err_count), .overrun_count(overrun_count));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  fr [25];
  logic [12:0] exp_q [$];
  int n_cmp = 0, n_fail = 0;
  int exp_err = 0, exp_ovr = 0;
  logic exp_fs = 1'b0, exp_fl = 1'b0;
  bit ack_en = 1'b0, done_exp = 1'b0;
  logic prev_valid = 1'b0;
  int unsigned t_rise = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pin level is the inverse of the logical line level.
  task automatic line_bit(input logic l);
    sbus_in = ~l;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) line_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(b[i]);
    line_bit((^b) ^ bad_par);
    line_bit(1'b1);
    line_bit(~bad_stop);
  endtask

  // Frame-level reference: a frame is good when every byte is clean, the header
  // is 0x0F and the footer 0x00; a good frame is delivered if nothing is pending.
  task automatic model_frame(input int bp, input int bs);
    if (bp >= 0 || bs >= 0 || fr[0] != 8'h0F || fr[24] != 8'h00) begin
      if (exp_err < 255) exp_err++;
    end else if (exp_q.size() == 0) begin
      for (int k = 0; k < 25; k++) exp_q.push_back({5'(k), fr[k]});
      exp_fs = fr[23][3];
      exp_fl = fr[23][2];
    end else begin
      if (exp_ovr < 255) exp_ovr++;
    end
  endtask

  task automatic send_frame(input int bp, input int bs);
    model_frame(bp, bs);
    idle_bits(GAP_BITS + 14);
    for (int k = 0; k < 25; k++) send_byte(fr[k], k == bp, k == bs);
    idle_bits(3);
  endtask

  task automatic check_status();
    chk("err_count", err_count, exp_err);
    chk("overrun_count", overrun_count, exp_ovr);
    chk("failsafe", failsafe, exp_fs);
    chk("frame_lost", frame_lost, exp_fl);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_complete", exp_q.size(), 0);
    idle_bits(1);
  endtask

  task automatic fill_rand();
    fr[0] = 8'h0F;
    for (int k = 1; k < 24; k++) fr[k] = 8'($urandom);
    fr[24] = 8'h00;
  endtask

  // Consumer: random acks (also while byte_valid is low, which must be ignored).
  initial begin
    byte_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      byte_ack = ack_en && ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks the done pulse.
  initial begin
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (done_exp || frame_done) chk("frame_done", frame_done, done_exp);
      done_exp = 1'b0;
      if (byte_valid && !prev_valid && byte_index == 5'd0) t_rise = cyc;
      prev_valid = byte_valid;
      if (reset_n && byte_valid && byte_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", byte_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("byte_index", byte_index, e[12:8]);
          chk("byte_data", byte_data, e[7:0]);
          if (e[12:8] == 5'd24) done_exp = 1'b1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, bp, bs;
    reset_n = 1'b0;
    sbus_in = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", byte_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_data", byte_data, 0);
    chk("rst_index", byte_index, 0);
    chk("rst_link_lost", link_lost, 1);
    check_status();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // 1: reference frame 0x0F, 0x01..0x16, 0x00, 0x00
    ack_en = 1'b1;
    fr[0] = 8'h0F;
    for (int k = 1; k <= 22; k++) fr[k] = 8'(k);
    fr[23] = 8'h00;
    fr[24] = 8'h00;
    chk("link_lost_before", link_lost, 1);
    send_frame(-1, -1);
    chk("link_lost_after", link_lost, 0);
    wait_drain();
    check_status();

    // 2: parity error in byte 5, then a clean frame
    fill_rand();
    send_frame(5, -1);
    chk("no_valid_par", byte_valid, 0);
    check_status();
    fill_rand();
    send_frame(-1, -1);
    wait_drain();
    check_status();

    // 3: bad header, then bad footer
    fill_rand();
    fr[0] = 8'h0E;
    send_frame(-1, -1);
    chk("no_valid_hdr", byte_valid, 0);
    check_status();
    fill_rand();
    fr[24] = 8'h04;
    send_frame(-1, -1);
    chk("no_valid_ftr", byte_valid, 0);
    check_status();

    // 4: consumer stalls; the second good frame is an overrun
    ack_en = 1'b0;
    fill_rand();
    fr[23] = 8'h08;
    send_frame(-1, -1);
    fill_rand();
    fr[23] = 8'h04;
    send_frame(-1, -1);
    check_status();
    ack_en = 1'b1;
    wait_drain();
    check_status();

    // 5: flag byte handling
    fill_rand();
    fr[23] = 8'h0C;
    send_frame(-1, -1);
    wait_drain();
    check_status();
    fill_rand();
    fr[23] = 8'h00;
    send_frame(-1, -1);
    wait_drain();
    check_status();

    // Random mix of clean and corrupted frames
    for (int r = 0; r < 5; r++) begin
      fill_rand();
      kind = $urandom_range(0, 4);
      bp = -1;
      bs = -1;
      case (kind)
        1: bp = $urandom_range(0, 24);
        2: bs = $urandom_range(0, 24);
        3: fr[0] = 8'h0F ^ 8'(1 << $urandom_range(0, 7));
        4: fr[24] = 8'(1 << $urandom_range(0, 7));
        default: ;
      endcase
      send_frame(bp, bs);
      wait_drain();
      check_status();
    end

    // 6a: short low glitch on an idle line
    sbus_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sbus_in = 1'b0;
    idle_bits(5);
    chk("glitch_valid", byte_valid, 0);
    check_status();

    // 6b: link timeout after the last good frame
    fill_rand();
    send_frame(-1, -1);
    wait_drain();
    while (cyc < t_rise + TO - 6) @(posedge clk);
    #1;
    chk("link_before_to", link_lost, 0);
    while (cyc < t_rise + TO + 6) @(posedge clk);
    #1;
    chk("link_after_to", link_lost, 1);
    check_status();

    // 6c: asynchronous reset in the middle of a drain
    ack_en = 1'b0;
    fill_rand();
    send_frame(-1, -1);
    chk("valid_before_rst", byte_valid, 1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("valid_async_rst", byte_valid, 0);
    chk("link_async_rst", link_lost, 1);
    exp_q.delete();
    exp_err = 0;
    exp_ovr = 0;
    exp_fs = 1'b0;
    exp_fl = 1'b0;
    check_status();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ack_en = 1'b1;
    fill_rand();
    send_frame(-1, -1);
    wait_drain();
    check_status();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
